// File: rtl/console_uart_tx_pkg.sv
// Shared definitions for the console UART: default addresses, status bit map, serialiser states.
package console_uart_tx_pkg;

  localparam logic [23:0] STDOUT_ADDR_DEF = 24'hFFFFFE;
  localparam logic [23:0] HALT_ADDR_DEF   = 24'hFFFFFF;

  localparam int unsigned STAT_EMPTY     = 0;
  localparam int unsigned STAT_FULL      = 1;
  localparam int unsigned STAT_BUSY      = 2;
  localparam int unsigned STAT_OVF       = 3;
  localparam int unsigned STAT_COUNT_LSB = 8;
  localparam int unsigned STAT_COUNT_MSB = 15;

  typedef enum logic [1:0] {
    TX_IDLE  = 2'd0,
    TX_START = 2'd1,
    TX_DATA  = 2'd2,
    TX_STOP  = 2'd3
  } tx_state_e;

endpackage

// File: rtl/sync_fifo.sv
// Single-clock FIFO with clock enable; a push while full is accepted when a pop happens in the same cycle.
module sync_fifo #(
  parameter int unsigned WIDTH = 8,
  parameter int unsigned DEPTH = 16,
  localparam int unsigned AW   = $clog2(DEPTH)
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             clk_en,
  input  logic             push,
  input  logic             pop,
  input  logic [WIDTH-1:0] din,
  output logic [WIDTH-1:0] dout,
  output logic [AW:0]      count,
  output logic             empty,
  output logic             full
);

  logic [WIDTH-1:0] mem [DEPTH];
  logic [AW-1:0]    wr_ptr;
  logic [AW-1:0]    rd_ptr;
  logic             do_push;
  logic             do_pop;

  assign empty   = (count == '0);
  assign full    = (count == (AW+1)'(DEPTH));
  assign do_pop  = pop && !empty;
  assign do_push = push && (!full || do_pop);
  assign dout    = mem[rd_ptr];

  always_ff @(posedge clk) begin
    if (rst) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else if (clk_en) begin
      if (do_push) wr_ptr <= wr_ptr + AW'(1);
      if (do_pop)  rd_ptr <= rd_ptr + AW'(1);
      case ({do_push, do_pop})
        2'b10:   count <= count + (AW+1)'(1);
        2'b01:   count <= count - (AW+1)'(1);
        default: ;
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (clk_en && do_push) mem[wr_ptr] <= din;
  end

endmodule

// File: rtl/console_uart_tx.sv
// Memory-mapped console: buffers STDOUT bytes, sends them as 8N1 UART frames, latches a sticky halt request.
module console_uart_tx
  import console_uart_tx_pkg::*;
#(
  parameter int unsigned       ADDR_W      = 24,
  parameter int unsigned       DATA_W      = 32,
  parameter logic [ADDR_W-1:0] STDOUT_ADDR = STDOUT_ADDR_DEF,
  parameter logic [ADDR_W-1:0] HALT_ADDR   = HALT_ADDR_DEF,
  parameter int unsigned       FIFO_DEPTH  = 16,
  parameter int unsigned       CLK_DIV     = 16
) (
  input  logic              i_clk,
  input  logic              i_rst,
  input  logic              i_clk_en,
  input  logic [ADDR_W-1:0] i_addr,
  input  logic              i_wr,
  input  logic              i_rd,
  input  logic [DATA_W-1:0] i_wdata,
  output logic [DATA_W-1:0] o_rdata,
  output logic              o_sel,
  output logic              o_txd,
  output logic              o_halt,
  output logic              o_drained
);

  localparam int unsigned   CW       = $clog2(FIFO_DEPTH) + 1;
  localparam int unsigned   BW       = $clog2(CLK_DIV);
  localparam logic [BW-1:0] BAUD_TOP = BW'(CLK_DIV - 1);

  logic          hit_stdout;
  logic          hit_halt;
  logic          push_req;
  logic          push_drop;
  logic          pop;
  logic          rd_status;
  logic          fifo_empty;
  logic          fifo_full;
  logic [7:0]    fifo_dout;
  logic [CW-1:0] fifo_count;
  logic          wdata_unused;

  tx_state_e     state_q, state_d;
  logic [BW-1:0] baud_q, baud_d;
  logic [2:0]    idx_q, idx_d;
  logic [7:0]    shift_q, shift_d;
  logic          txd_q, txd_d;
  logic          ovf_q;
  logic          halt_q;

  assign hit_stdout   = (i_addr == STDOUT_ADDR);
  assign hit_halt     = (i_addr == HALT_ADDR);
  assign o_sel        = hit_stdout || hit_halt;
  assign push_req     = i_clk_en && i_wr && hit_stdout;
  assign rd_status    = i_rd && hit_stdout;
  assign pop          = i_clk_en && (state_q == TX_IDLE) && !fifo_empty;
  assign push_drop    = push_req && fifo_full && !pop;
  assign wdata_unused = ^i_wdata[DATA_W-1:8];

  sync_fifo #(
    .WIDTH (8),
    .DEPTH (FIFO_DEPTH)
  ) u_fifo (
    .clk    (i_clk),
    .rst    (i_rst),
    .clk_en (i_clk_en),
    .push   (push_req),
    .pop    (pop),
    .din    (i_wdata[7:0]),
    .dout   (fifo_dout),
    .count  (fifo_count),
    .empty  (fifo_empty),
    .full   (fifo_full)
  );

  // txd is derived from the next state so the pin is registered yet goes low on the pop edge.
  always_comb begin
    state_d = state_q;
    baud_d  = baud_q;
    idx_d   = idx_q;
    shift_d = shift_q;
    txd_d   = 1'b1;
    case (state_q)
      TX_IDLE: if (!fifo_empty) begin
        shift_d = fifo_dout;
        baud_d  = BAUD_TOP;
        state_d = TX_START;
      end
      TX_START: if (baud_q == '0) begin
        baud_d  = BAUD_TOP;
        idx_d   = '0;
        state_d = TX_DATA;
      end else begin
        baud_d  = baud_q - BW'(1);
      end
      TX_DATA: if (baud_q == '0) begin
        baud_d  = BAUD_TOP;
        shift_d = {1'b0, shift_q[7:1]};
        idx_d   = idx_q + 3'd1;
        if (idx_q == 3'd7) state_d = TX_STOP;
      end else begin
        baud_d  = baud_q - BW'(1);
      end
      TX_STOP: if (baud_q == '0) begin
        state_d = TX_IDLE;
      end else begin
        baud_d  = baud_q - BW'(1);
      end
      default: state_d = TX_IDLE;
    endcase
    case (state_d)
      TX_START: txd_d = 1'b0;
      TX_DATA:  txd_d = shift_d[0];
      default:  txd_d = 1'b1;
    endcase
  end

  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      state_q <= TX_IDLE;
      baud_q  <= '0;
      idx_q   <= '0;
      shift_q <= '0;
      txd_q   <= 1'b1;
      ovf_q   <= 1'b0;
      halt_q  <= 1'b0;
    end else if (i_clk_en) begin
      state_q <= state_d;
      baud_q  <= baud_d;
      idx_q   <= idx_d;
      shift_q <= shift_d;
      txd_q   <= txd_d;
      if (push_drop)      ovf_q <= 1'b1;
      else if (rd_status) ovf_q <= 1'b0;
      if (i_wr && hit_halt) halt_q <= 1'b1;
    end
  end

  always_comb begin
    o_rdata = '0;
    if (rd_status) begin
      o_rdata[STAT_EMPTY] = fifo_empty;
      o_rdata[STAT_FULL]  = fifo_full;
      o_rdata[STAT_BUSY]  = (state_q != TX_IDLE);
      o_rdata[STAT_OVF]   = ovf_q;
      o_rdata[STAT_COUNT_MSB:STAT_COUNT_LSB] = 8'(fifo_count);
    end
  end

  assign o_txd     = txd_q;
  assign o_halt    = halt_q;
  assign o_drained = halt_q && fifo_empty && (state_q == TX_IDLE);

endmodule

// File: tb/tb_console_uart_tx.sv
// Directed bench for console_uart_tx: bytes queued on write are checked against frames decoded from o_txd.
module tb_console_uart_tx;

  localparam int unsigned CLK_DIV    = 4;
  localparam int unsigned FIFO_DEPTH = 16;
  localparam logic [23:0] A_STDOUT   = 24'hFFFFFE;
  localparam logic [23:0] A_HALT     = 24'hFFFFFF;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        clk_en = 1'b1;
  logic        wr = 1'b0;
  logic        rd = 1'b0;
  logic [23:0] addr = '0;
  logic [31:0] wdata = '0;
  logic [31:0] rdata;
  logic        sel, txd, halt, drained;

  int unsigned vectors = 0;
  int unsigned miscompares = 0;
  int unsigned frames_done = 0;
  logic [7:0]  sb[$];

  always #5 clk = ~clk;

  console_uart_tx #(
    .ADDR_W      (24),
    .DATA_W      (32),
    .STDOUT_ADDR (A_STDOUT),
    .HALT_ADDR   (A_HALT),
    .FIFO_DEPTH  (FIFO_DEPTH),
    .CLK_DIV     (CLK_DIV)
  ) dut (
    .i_clk     (clk),
    .i_rst     (rst),
    .i_clk_en  (clk_en),
    .i_addr    (addr),
    .i_wr      (wr),
    .i_rd      (rd),
    .i_wdata   (wdata),
    .o_rdata   (rdata),
    .o_sel     (sel),
    .o_txd     (txd),
    .o_halt    (halt),
    .o_drained (drained)
  );

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    vectors++;
    assert (obs === exp) else begin
      miscompares++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  // UART decoder: one sample per enabled clock, taken just after the edge.
  typedef enum {M_IDLE, M_START, M_DATA, M_STOP} mon_e;
  mon_e        mstate = M_IDLE;
  int unsigned mcnt = 0;
  int unsigned mbit = 0;
  logic [7:0]  mbyte = '0;
  logic        bitval = 1'b0;

  initial forever begin
    @(posedge clk);
    if (rst) begin
      mstate = M_IDLE;
    end else if (clk_en) begin
      #1;
      case (mstate)
        M_IDLE: if (txd === 1'b0) begin
          mstate = M_START;
          mcnt   = 1;
        end
        M_START: begin
          check("start_bit", 32'(txd), 32'd0);
          mcnt++;
          if (mcnt == CLK_DIV) begin
            mstate = M_DATA;
            mcnt   = 0;
            mbit   = 0;
          end
        end
        M_DATA: begin
          if (mcnt == 0) bitval = txd;
          else check("bit_hold", 32'(txd), 32'(bitval));
          mcnt++;
          if (mcnt == CLK_DIV) begin
            mbyte[mbit] = bitval;
            mcnt = 0;
            mbit++;
            if (mbit == 8) mstate = M_STOP;
          end
        end
        M_STOP: begin
          check("stop_bit", 32'(txd), 32'd1);
          mcnt++;
          if (mcnt == CLK_DIV) begin
            check("frame_expected", 32'(sb.size() > 0), 32'd1);
            if (sb.size() > 0) check("frame_byte", 32'(mbyte), 32'(sb.pop_front()));
            frames_done++;
            mstate = M_IDLE;
          end
        end
        default: mstate = M_IDLE;
      endcase
    end
  end

  task automatic wr_to(input logic [23:0] a, input logic [31:0] d);
    wr = 1'b1; addr = a; wdata = d;
    @(negedge clk);
    wr = 1'b0; addr = '0; wdata = '0;
  endtask

  task automatic send(input logic [7:0] b);
    sb.push_back(b);
    wr_to(A_STDOUT, {24'hABCDEF, b});
  endtask

  task automatic status(input string tag, input logic [31:0] exp, input bit clocked);
    rd = 1'b1; addr = A_STDOUT;
    #1 check(tag, rdata, exp);
    if (clocked) @(negedge clk);
    rd = 1'b0; addr = '0;
  endtask

  task automatic wait_frames(input int unsigned target, input int unsigned budget);
    int unsigned n = 0;
    while (frames_done < target && n < budget) begin
      @(negedge clk);
      n++;
    end
    check("frame_timeout", 32'(frames_done >= target), 32'd1);
  endtask

  task automatic wait_drained(input int unsigned budget);
    int unsigned n = 0;
    while (!drained && n < budget) begin
      @(negedge clk);
      n++;
    end
    check("drained_timeout", 32'(drained), 32'd1);
  endtask

  initial begin
    int unsigned f0;
    int unsigned n;

    repeat (2) @(negedge clk);
    rst = 1'b0;
    check("rst_txd", 32'(txd), 32'd1);
    check("rst_halt", 32'(halt), 32'd0);
    check("rst_drained", 32'(drained), 32'd0);
    check("rdata_not_reading", rdata, 32'd0);
    status("rst_status", 32'h00000001, 1'b0);

    // Single byte: latency, start width, first data bit, then decoder checks the rest.
    f0 = frames_done;
    send(8'h41);
    check("lat_pre", 32'(txd), 32'd1);
    @(negedge clk);
    check("lat_start", 32'(txd), 32'd0);
    repeat (3) @(negedge clk);
    check("start_hold", 32'(txd), 32'd0);
    @(negedge clk);
    check("bit0", 32'(txd), 32'd1);
    wait_frames(f0 + 1, 60);
    @(negedge clk);
    status("idle_status", 32'h00000001, 1'b0);

    // Fill past depth: 17 accepted, 18th dropped, read-vs-overflow precedence, clear on read.
    f0 = frames_done;
    for (int i = 0; i < 17; i++) send(8'h30 + 8'(i));
    wr_to(A_STDOUT, 32'h000000EE);
    wr = 1'b1; rd = 1'b1; addr = A_STDOUT; wdata = 32'h000000EF;
    #1 check("full_ovf_status", rdata, 32'h0000100E);
    @(negedge clk);
    wr = 1'b0; rd = 1'b0; addr = '0; wdata = '0;
    status("ovf_kept", 32'h0000100E, 1'b1);
    status("ovf_cleared", 32'h00001006, 1'b0);
    wait_frames(f0 + 17, 17 * 45 + 40);
    @(negedge clk);

    // Clock enable low: pushes and halts ignored, decode still follows inputs.
    clk_en = 1'b0;
    wr_to(A_STDOUT, 32'h00000077);
    wr_to(A_HALT, 32'h00000001);
    addr = A_HALT;
    #1 check("sel_while_disabled", 32'(sel), 32'd1);
    addr = '0;
    check("halt_ignored", 32'(halt), 32'd0);
    status("push_ignored", 32'h00000001, 1'b0);
    clk_en = 1'b1;

    // 50% clock enable during a frame.
    f0 = frames_done;
    send(8'h5A);
    n = 0;
    while (frames_done < f0 + 1 && n < 200) begin
      clk_en = ~clk_en;
      @(negedge clk);
      n++;
    end
    clk_en = 1'b1;
    check("stretched_frame", 32'(frames_done), 32'(f0 + 1));
    repeat (2) @(negedge clk);

    // Halt with three bytes queued.
    f0 = frames_done;
    send(8'hA1);
    send(8'hA2);
    send(8'hA3);
    wr_to(A_HALT, 32'hDEADBEEF);
    check("halt_set", 32'(halt), 32'd1);
    check("drained_early", 32'(drained), 32'd0);
    wait_drained(200);
    check("drained_after_frames", 32'(frames_done), 32'(f0 + 3));
    send(8'hB4);
    check("drained_drop", 32'(drained), 32'd0);
    check("halt_sticky", 32'(halt), 32'd1);
    wait_drained(80);
    check("drained_again_frames", 32'(frames_done), 32'(f0 + 4));

    // Five queued while transmitting, address decode, HALT reads as zero.
    for (int i = 0; i < 6; i++) send(8'hC0 + 8'(i));
    status("status_5_busy", 32'h00000504, 1'b0);
    addr = A_STDOUT;
    #1 check("sel_stdout", 32'(sel), 32'd1);
    addr = A_HALT; rd = 1'b1;
    #1 check("sel_halt", 32'(sel), 32'd1);
    check("rdata_halt_addr", rdata, 32'd0);
    addr = 24'hFFFFFD;
    #1 check("sel_other", 32'(sel), 32'd0);
    check("rdata_other", rdata, 32'd0);
    rd = 1'b0; addr = '0;

    // Reset in the middle of data bit 3.
    n = 0;
    while (!(mstate == M_DATA && mbit == 3) && n < 100) begin
      @(negedge clk);
      n++;
    end
    check("reach_bit3", 32'(mstate == M_DATA && mbit == 3), 32'd1);
    rst = 1'b1;
    @(negedge clk);
    rst = 1'b0;
    sb.delete();
    check("midrst_txd", 32'(txd), 32'd1);
    check("midrst_halt", 32'(halt), 32'd0);
    check("midrst_drained", 32'(drained), 32'd0);
    status("midrst_status", 32'h00000001, 1'b0);
    repeat (8) @(negedge clk);
    check("midrst_quiet", 32'(txd), 32'd1);

    f0 = frames_done;
    send(8'hC3);
    wait_frames(f0 + 1, 60);

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
